// File: rtl/sap_alu_pkg.sv
// Shared types and constants for the SAP ALU.
// Op encoding, default width and flag bit positions.
package sap_alu_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_t;

  localparam int ALU_WIDTH_DEF = 8;

  localparam int FLAG_V = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 3;
  localparam int FLAG_W = 4;

endpackage

// File: rtl/sap_alu_addsub.sv
// Adder/subtractor for the SAP ALU.
// SUB is A + ~B + 1, so carry out means no borrow.
module sap_alu_addsub #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             ovf_o
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   full;

  assign b_eff = sub_i ? ~b_i : b_i;
  assign full  = {1'b0, a_i} + {1'b0, b_eff}
               + {{WIDTH{1'b0}}, sub_i};

  assign sum_o   = full[WIDTH-1:0];
  assign carry_o = full[WIDTH];
  // Same-sign operands into the adder producing a different-sign result
  assign ovf_o   = (a_i[WIDTH-1] == b_eff[WIDTH-1])
                && (sum_o[WIDTH-1] != a_i[WIDTH-1]);

endmodule

// File: rtl/sap_alu.sv
// SAP ALU: op mux, W-bus output gating and C/Z/N/V flags register.
// Define SAP_ALU_TRISTATE_EN to float ALU_Out when eu=0.
module sap_alu
  import sap_alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  input  logic [1:0]       su,
  input  logic             eu,
  output logic [WIDTH-1:0] ALU_Out,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v
);

  alu_op_t          op;
  logic [WIDTH-1:0] as_sum;
  logic             as_c;
  logic             as_v;
  logic [WIDTH-1:0] r;
  logic             c;
  logic             v;
  logic [FLAG_W-1:0] flags_d;
  logic [FLAG_W-1:0] flags_q;

  assign op = alu_op_t'(su);

  sap_alu_addsub #(
    .WIDTH (WIDTH)
  ) u_addsub (
    .a_i     (A_in),
    .b_i     (B_in),
    .sub_i   (op == ALU_SUB),
    .sum_o   (as_sum),
    .carry_o (as_c),
    .ovf_o   (as_v)
  );

  always_comb begin
    r = '0;
    c = 1'b0;
    v = 1'b0;
    unique case (op)
      ALU_ADD, ALU_SUB: begin
        r = as_sum;
        c = as_c;
        v = as_v;
      end
      ALU_AND: r = A_in & B_in;
      ALU_OR:  r = A_in | B_in;
      default: r = '0;
    endcase
  end

`ifdef SAP_ALU_TRISTATE_EN
  assign ALU_Out = eu ? r : {WIDTH{1'bz}};
`else
  assign ALU_Out = eu ? r : '0;
`endif

  always_comb begin
    flags_d = flags_q;
    if (eu) begin
      flags_d[FLAG_C] = c;
      flags_d[FLAG_Z] = (r == '0);
      flags_d[FLAG_N] = r[WIDTH-1];
      flags_d[FLAG_V] = v;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) flags_q <= '0;
    else     flags_q <= flags_d;
  end

  assign flag_c = flags_q[FLAG_C];
  assign flag_z = flags_q[FLAG_Z];
  assign flag_n = flags_q[FLAG_N];
  assign flag_v = flags_q[FLAG_V];

endmodule

// File: tb/tb_sap_alu.sv
// Self-checking bench for sap_alu: vector table plus flag scoreboard.
// Flags are packed {C,Z,N,V} in expected values.
module tb_sap_alu;

  logic       clk;
  logic       rst;
  logic [7:0] A_in;
  logic [7:0] B_in;
  logic [1:0] su;
  logic       eu;
  logic [7:0] ALU_Out;
  logic       flag_c;
  logic       flag_z;
  logic       flag_n;
  logic       flag_v;

  int checks = 0;
  int errors = 0;

  logic [3:0] sb_q[$];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
    logic [7:0] out;
    logic [3:0] flg;
  } vec_t;

  vec_t vecs[8];

  sap_alu #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .A_in    (A_in),
    .B_in    (B_in),
    .su      (su),
    .eu      (eu),
    .ALU_Out (ALU_Out),
    .flag_c  (flag_c),
    .flag_z  (flag_z),
    .flag_n  (flag_n),
    .flag_v  (flag_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] flags();
    return {flag_c, flag_z, flag_n, flag_v};
  endfunction

  task automatic pop_chk(input string name);
    logic [3:0] e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb_q.pop_front();
      chk(name, {4'h0, flags()}, {4'h0, e});
    end
  endtask

  logic [7:0] idle_out;
  logic [3:0] last_flg;

  initial begin
`ifdef SAP_ALU_TRISTATE_EN
    idle_out = 8'hzz;
`else
    idle_out = 8'h00;
`endif
    vecs[0] = '{8'h05, 8'h03, 2'b00, 8'h08, 4'b0000};
    vecs[1] = '{8'hFF, 8'h01, 2'b00, 8'h00, 4'b1100};
    vecs[2] = '{8'h7F, 8'h01, 2'b00, 8'h80, 4'b0011};
    vecs[3] = '{8'h03, 8'h05, 2'b01, 8'hFE, 4'b0010};
    vecs[4] = '{8'h05, 8'h05, 2'b01, 8'h00, 4'b1100};
    vecs[5] = '{8'hF0, 8'h3C, 2'b10, 8'h30, 4'b0000};
    vecs[6] = '{8'hF0, 8'h3C, 2'b11, 8'hFC, 4'b0010};
    vecs[7] = '{8'h80, 8'h01, 2'b01, 8'h7F, 4'b1001};

    rst  = 1'b1;
    A_in = 8'h00;
    B_in = 8'h00;
    su   = 2'b00;
    eu   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_flags", {4'h0, flags()}, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      A_in = vecs[i].a;
      B_in = vecs[i].b;
      su   = vecs[i].op;
      eu   = 1'b1;
      sb_q.push_back(vecs[i].flg);
      #1;
      chk($sformatf("out[%0d]", i), ALU_Out, vecs[i].out);
      @(posedge clk);
      #1;
      pop_chk($sformatf("flags[%0d]", i));
    end
    last_flg = vecs[7].flg;

    // eu=0: bus idle and flags held over three edges
    @(negedge clk);
    A_in = 8'h05;
    B_in = 8'h03;
    su   = 2'b00;
    eu   = 1'b0;
    #1;
    chk("eu0_out", ALU_Out, idle_out);
    for (int k = 0; k < 3; k++) begin
      sb_q.push_back(last_flg);
      @(posedge clk);
      #1;
      pop_chk($sformatf("eu0_hold[%0d]", k));
    end

    // Operand change between edges: output follows, flags wait
    @(negedge clk);
    A_in = 8'h80;
    B_in = 8'h01;
    su   = 2'b01;
    eu   = 1'b1;
    #1;
    chk("mid_out", ALU_Out, 8'h7F);
    chk("mid_flags", {4'h0, flags()}, {4'h0, last_flg});

    // Async reset between edges
    #1;
    rst = 1'b1;
    #1;
    chk("rst_async_flags", {4'h0, flags()}, 8'h00);
    chk("rst_out", ALU_Out, 8'h7F);
    @(posedge clk);
    #1;
    chk("rst_held_flags", {4'h0, flags()}, 8'h00);

    // Release reset, next eu=1 edge reloads
    @(negedge clk);
    rst  = 1'b0;
    A_in = 8'h7F;
    B_in = 8'h01;
    su   = 2'b00;
    sb_q.push_back(4'b0011);
    @(posedge clk);
    #1;
    pop_chk("post_rst_flags");
    chk("post_rst_out", ALU_Out, 8'h80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
